// File: rtl/kv_lookup_responder.sv
// Direct-mapped key table (insert/lookup/delete) answering encap-engine requests; KV_STATS_EN adds a LOOKUP-hit counter on debug.
// Latency: fixed 3 cycles from in_valid to out_valid; one result per request, throughput 1/cycle.
// Backpressure: none; every accepted request is processed, with same-index hazards forwarded in-pipe.
module kv_lookup_responder #(
  parameter int KEY_SIZE = 96,
  parameter int IDX_W    = 8
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic [7:0]          debug
);

  localparam int NCHUNK = (KEY_SIZE + IDX_W - 1) / IDX_W;
  localparam int DEPTH  = 1 << IDX_W;

  localparam logic [3:0] OP_LOOKUP = 4'b0001;
  localparam logic [3:0] OP_INSERT = 4'b0010;
  localparam logic [3:0] OP_DELETE = 4'b0100;

  // Index: XOR-fold of the key, top chunk zero-extended when KEY_SIZE is not a multiple of IDX_W.
  logic [NCHUNK*IDX_W-1:0] key_pad;
  logic [IDX_W-1:0]        in_idx;

  always_comb begin
    key_pad                 = '0;
    key_pad[KEY_SIZE-1:0]   = in_key;
    in_idx                  = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      in_idx = in_idx ^ key_pad[i*IDX_W +: IDX_W];
    end
  end

  // S1 pipeline valid; requests seen during reset are dropped.
  logic                s1_vld_q;
  logic [KEY_SIZE-1:0] s1_key_q;
  logic [3:0]          s1_op_q;
  logic [IDX_W-1:0]    s1_idx_q;

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) s1_vld_q <= 1'b0;
    else            s1_vld_q <= in_valid;
  end

  // S1 payload capture; qualified by s1_vld_q so no reset needed.
  always_ff @(posedge clk156) begin
    s1_key_q <= in_key;
    s1_op_q  <= in_flag;
    s1_idx_q <= in_idx;
  end

  // S2 pipeline valid.
  logic                s2_vld_q;
  logic [KEY_SIZE-1:0] s2_key_q;
  logic [3:0]          s2_op_q;
  logic [IDX_W-1:0]    s2_idx_q;

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) s2_vld_q <= 1'b0;
    else            s2_vld_q <= s1_vld_q;
  end

  // S2 payload capture.
  always_ff @(posedge clk156) begin
    s2_key_q <= s1_key_q;
    s2_op_q  <= s1_op_q;
    s2_idx_q <= s1_idx_q;
  end

  // Key storage: synchronous-read RAM, written from S2, read for the request in S1.
  logic [KEY_SIZE-1:0] key_ram [DEPTH];
  logic [KEY_SIZE-1:0] ram_rd_q;
  logic                key_wr_en;

  // RAM write port (S2 decision) and registered read port (S1 index).
  always_ff @(posedge clk156) begin
    if (key_wr_en) key_ram[s2_idx_q] <= s2_key_q;
    ram_rd_q <= key_ram[s1_idx_q];
  end

  // The RAM returns old data when S2 writes the index S1 is reading on the same edge,
  // so the written key is captured alongside and substituted in S2.
  logic                fwd_hit_q;
  logic [KEY_SIZE-1:0] fwd_key_q;

  always_ff @(posedge clk156) begin
    fwd_hit_q <= key_wr_en && (s2_idx_q == s1_idx_q);
    fwd_key_q <= s2_key_q;
  end

  // Valid bits live in flops and are read combinationally in S2, so the previous
  // request's update (made at the preceding edge) is always visible without a bypass.
  logic [DEPTH-1:0]    valid_q;
  logic [KEY_SIZE-1:0] stored_key;
  logic                ent_vld;
  logic                hit;
  logic                vld_wr_en;
  logic                vld_wr_val;
  logic [3:0]          flag_d;

  assign stored_key = fwd_hit_q ? fwd_key_q : ram_rd_q;
  assign ent_vld    = valid_q[s2_idx_q];
  assign hit        = ent_vld && (stored_key == s2_key_q);

  // S2 decision: result flags and table updates for the request in S2.
  always_comb begin
    flag_d     = 4'b0000;
    key_wr_en  = 1'b0;
    vld_wr_en  = 1'b0;
    vld_wr_val = 1'b0;
    if (s2_vld_q) begin
      case (s2_op_q)
        OP_LOOKUP: flag_d = hit ? 4'b0001 : 4'b0000;
        OP_INSERT: begin
          key_wr_en  = 1'b1;
          vld_wr_en  = 1'b1;
          vld_wr_val = 1'b1;
          if (hit)          flag_d = 4'b0011;
          else if (ent_vld) flag_d = 4'b0110;
          else              flag_d = 4'b0010;
        end
        OP_DELETE: begin
          if (hit) begin
            vld_wr_en  = 1'b1;
            vld_wr_val = 1'b0;
            flag_d     = 4'b0011;
          end
        end
        default: flag_d = 4'b1000;
      endcase
    end
  end

  // Valid-bit table update; reset empties the table.
  always_ff @(posedge clk156) begin
    if (!eth_rst_n)     valid_q <= '0;
    else if (vld_wr_en) valid_q[s2_idx_q] <= vld_wr_val;
  end

  // Registered result; flag_d is already zero when S2 is idle.
  logic       out_valid_q;
  logic [3:0] out_flag_q;

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      out_valid_q <= 1'b0;
      out_flag_q  <= 4'b0000;
    end else begin
      out_valid_q <= s2_vld_q;
      out_flag_q  <= flag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flag  = out_flag_q;

`ifdef KV_STATS_EN
  logic       lookup_hit;
  logic [7:0] hit_cnt_q;

  assign lookup_hit = s2_vld_q && (s2_op_q == OP_LOOKUP) && hit;

  // Saturating count of LOOKUP hits.
  always_ff @(posedge clk156) begin
    if (!eth_rst_n)                          hit_cnt_q <= 8'h00;
    else if (lookup_hit && hit_cnt_q != 8'hFF) hit_cnt_q <= hit_cnt_q + 8'd1;
  end

  assign debug = hit_cnt_q;
`else
  assign debug = 8'h00;
`endif

endmodule

// File: tb/tb_kv_lookup_responder.sv
// Directed bench for kv_lookup_responder: scoreboard queue filled by the driver,
// drained by a negedge monitor that checks flag value and exact 3-cycle arrival.
module tb_kv_lookup_responder;

  localparam logic [3:0] LK = 4'b0001;
  localparam logic [3:0] IN = 4'b0010;
  localparam logic [3:0] DL = 4'b0100;

  logic        clk156    = 1'b0;
  logic        eth_rst_n = 1'b0;
  logic [95:0] in_key    = '0;
  logic [3:0]  in_flag   = '0;
  logic        in_valid  = 1'b0;
  logic        out_valid;
  logic [3:0]  out_flag;
  logic [7:0]  debug;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int         due;
    logic [3:0] flag;
  } exp_t;

  exp_t sb[$];

  kv_lookup_responder #(.KEY_SIZE(96), .IDX_W(8)) dut (
    .clk156    (clk156),
    .eth_rst_n (eth_rst_n),
    .in_key    (in_key),
    .in_flag   (in_flag),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .out_flag  (out_flag),
    .debug     (debug)
  );

  always #5 clk156 = ~clk156;

  always @(posedge clk156) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive a request in the current cycle and record its expected result.
  task automatic drive(input logic [95:0] k, input logic [3:0] f, input logic [3:0] ef);
    exp_t e;
    in_key   = k;
    in_flag  = f;
    in_valid = 1'b1;
    e.due    = cyc + 3;
    e.flag   = ef;
    sb.push_back(e);
  endtask

  task automatic req(input logic [95:0] k, input logic [3:0] f, input logic [3:0] ef);
    @(negedge clk156);
    drive(k, f, ef);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk156);
      in_valid = 1'b0;
      in_flag  = 4'b0000;
    end
  endtask

  // Monitor: every out_valid must match the oldest expectation, in exactly its due cycle.
  always @(negedge clk156) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: out_valid=1 flag=%b with nothing outstanding (cycle %0d)", out_flag, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.due != cyc || out_flag !== e.flag) begin
            failures++;
            $display("FAIL out_result: got flag %b at cycle %0d, expected flag %b at cycle %0d",
                     out_flag, cyc, e.flag, e.due);
          end
        end
      end else begin
        checks++;
        if (out_flag !== 4'b0000) begin
          failures++;
          $display("FAIL idle_flag: got %b expected 0000 while out_valid low (cycle %0d)", out_flag, cyc);
        end
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          failures++;
          $display("FAIL out_missing: no out_valid by cycle %0d, expected flag %b due at cycle %0d",
                   cyc, e.flag, e.due);
        end
      end
    end
  end

  localparam logic [95:0] K1 = 96'h0000_0000_0000_0000_0000_0033;
  localparam logic [95:0] K2 = 96'h0101_0000_0000_0000_0000_0033;
  localparam logic [95:0] KX = 96'h0102_0304_0506_0708_090A_0B0C;

  initial begin
    // Reset and reset-state checks.
    repeat (3) @(negedge clk156);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_out_flag",  {4'b0, out_flag},  8'h00);
    chk("rst_debug",     debug,             8'h00);
    eth_rst_n = 1'b1;
    mon_en    = 1'b1;

    // First request after reset: empty table miss.
    req(96'h1, LK, 4'b0000);
    idle(2);

    // Insert then immediate lookup (same index back-to-back), then re-insert hit.
    req(96'hA5, IN, 4'b0010);
    req(96'hA5, LK, 4'b0001);
    req(96'hA5, IN, 4'b0011);
    idle(2);

    // Same-fold collision: K2 overwrites K1.
    req(K1, IN, 4'b0010);
    req(K2, IN, 4'b0110);
    req(K1, LK, 4'b0000);
    req(K2, LK, 4'b0001);
    idle(2);

    // Insert / delete / delete / lookup on consecutive cycles.
    req(96'h55, IN, 4'b0010);
    req(96'h55, DL, 4'b0011);
    req(96'h55, DL, 4'b0000);
    req(96'h55, LK, 4'b0000);
    idle(1);

    // Invalid opcodes change nothing.
    req(96'h77, 4'b0011, 4'b1000);
    req(96'h77, 4'b0000, 4'b1000);
    req(96'h77, 4'b1000, 4'b1000);
    req(96'h77, LK, 4'b0000);
    req(96'h99, DL, 4'b0000);
    idle(2);

    // Full-width fold: KX folds to index 0x0C, same as key 0xC.
    req(KX,     IN, 4'b0010);
    req(96'hC,  LK, 4'b0000);
    req(96'hC,  IN, 4'b0110);
    req(KX,     LK, 4'b0000);
    idle(3);

    // Long stream of lookup hits with a reset pulse mid-stream.
    req(96'hBEEF, IN, 4'b0010);
    for (int i = 0; i < 280; i++) req(96'hBEEF, LK, 4'b0001);
    @(negedge clk156);
`ifdef KV_STATS_EN
    chk("debug_saturated", debug, 8'hFF);
`else
    chk("debug_tied", debug, 8'h00);
`endif
    // Reset asserted with a request present: the request is ignored, in-flight ones vanish.
    eth_rst_n = 1'b0;
    in_key    = 96'hBEEF;
    in_flag   = LK;
    in_valid  = 1'b1;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    @(negedge clk156);
    eth_rst_n = 1'b1;
    chk("midrst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("midrst_out_flag",  {4'b0, out_flag},  8'h00);
    chk("midrst_debug",     debug,             8'h00);
    // Request in the cycle reset rises is processed; table was cleared.
    drive(96'hBEEF, LK, 4'b0000);
    for (int i = 0; i < 18; i++) req(96'hBEEF, LK, 4'b0000);
    req(96'hBEEF, IN, 4'b0010);
    req(96'hBEEF, LK, 4'b0001);
    idle(6);
`ifdef KV_STATS_EN
    chk("debug_after", debug, 8'h01);
`else
    chk("debug_after", debug, 8'h00);
`endif

    chk("sb_drained", sb.size() > 255 ? 8'hFF : 8'(sb.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
